// File: rtl/lsu_bus_master_if.sv
// Data-memory bus between the load/store unit and memory.
// Ports (no interface ports; signals only):
//   bus_req/bus_we/bus_addr/bus_wstrb/bus_wdata : master -> slave request
//   bus_gnt/bus_rvalid/bus_rdata                : slave -> master response
interface lsu_bus_master_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/lsu_bus_master.sv
// Load/store unit: turns a MEM-stage load/store into a word-aligned bus
// transaction with byte strobes, realigns and extends load data, stalls the
// pipeline until completion and flags misaligned accesses without bus use.
// Ports:
//   clk, rst_n (sync, active-low)
//   mem_valid, is_load, is_store, load[2:0], store[1:0], mem_addr, mem_wdata
//   stall, done, misalign, mem_rdata
//   bus : lsu_bus_master_if.master
//
// state  | meaning
// IDLE   | waiting for a MEM-stage access
// REQ    | bus_req high, bus outputs held until bus_gnt
// WAIT_R | load granted, waiting for bus_rvalid
// DONE   | one-cycle completion pulse
module lsu_bus_master (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  load,
  input  logic [1:0]  store,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        stall,
  output logic        done,
  output logic        misalign,
  output logic [31:0] mem_rdata,
  lsu_bus_master_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

  state_t      state, state_nxt;
  logic        access, wr, is_half, is_byte, mis;
  logic [3:0]  strb_n;
  logic [31:0] wdata_n, shifted, ext;

  logic        we_q, mis_q;
  logic [1:0]  off_q;
  logic [2:0]  ld_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  strb_q;

  assign access = mem_valid & (is_load | is_store);
  assign wr     = is_store;  // store wins when both are set

  // Unlisted size codes fall through as word accesses.
  assign is_half = wr ? (store == 2'b01) : (load == 3'b001 || load == 3'b011);
  assign is_byte = wr ? (store == 2'b10) : (load == 3'b010 || load == 3'b100);
  assign mis     = is_half ? mem_addr[0] :
                   is_byte ? 1'b0 : (mem_addr[1:0] != 2'b00);

  always_comb begin
    strb_n  = 4'b0000;
    wdata_n = 32'h0;
    if (wr) begin
      if (is_byte) begin
        strb_n  = 4'b0001 << mem_addr[1:0];
        wdata_n = {4{mem_wdata[7:0]}};
      end else if (is_half) begin
        strb_n  = mem_addr[1] ? 4'b1100 : 4'b0011;
        wdata_n = {2{mem_wdata[15:0]}};
      end else begin
        strb_n  = 4'b1111;
        wdata_n = mem_wdata;
      end
    end
  end

  assign shifted = bus.bus_rdata >> {off_q, 3'b000};

  always_comb begin
    case (ld_q)
      3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b011:  ext = {16'h0, shifted[15:0]};
      3'b010:  ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  ext = {24'h0, shifted[7:0]};
      default: ext = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (access) state_nxt = mis ? DONE : REQ;
      REQ:     if (bus.bus_gnt) state_nxt = we_q ? DONE : WAIT_R;
      WAIT_R:  if (bus.bus_rvalid) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.bus_req = (state == REQ);
    done        = (state == DONE);
    misalign    = (state == DONE) & mis_q;
    stall       = (state == REQ) | (state == WAIT_R) | ((state == IDLE) & access);
  end

  // Bus-side registers only change in IDLE, so they stay bit-stable through REQ.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      off_q   <= 2'b00;
      ld_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      strb_q  <= 4'b0000;
      rdata_q <= 32'h0;
    end else begin
      if (state == IDLE && access) begin
        mis_q <= mis;
        if (!mis) begin
          we_q    <= wr;
          off_q   <= mem_addr[1:0];
          ld_q    <= load;
          addr_q  <= {mem_addr[31:2], 2'b00};
          wdata_q <= wdata_n;
          strb_q  <= strb_n;
        end
      end
      if (state == WAIT_R && bus.bus_rvalid) rdata_q <= ext;
    end
  end

  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wstrb = strb_q;
  assign bus.bus_wdata = wdata_q;
  assign mem_rdata     = rdata_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
module tb_lsu_bus_master;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid, is_load, is_store;
  logic [2:0]  load;
  logic [1:0]  store;
  logic [31:0] mem_addr, mem_wdata;
  logic        stall, done, misalign;
  logic [31:0] mem_rdata;
  int          total = 0;
  int          bad = 0;

  lsu_bus_master_if bus_if ();

  lsu_bus_master dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_valid (mem_valid),
    .is_load   (is_load),
    .is_store  (is_store),
    .load      (load),
    .store     (store),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .stall     (stall),
    .done      (done),
    .misalign  (misalign),
    .mem_rdata (mem_rdata),
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
    bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0;
  endtask

  task automatic do_store(input string tag, input logic [1:0] st, input logic both,
                          input logic [31:0] addr, input logic [31:0] wd, input int gdly,
                          input logic [31:0] e_addr, input logic [3:0] e_strb,
                          input logic [31:0] e_wd);
    @(negedge clk);
    mem_valid = 1'b1; is_store = 1'b1; is_load = both; store = st;
    mem_addr = addr; mem_wdata = wd;
    #1;
    check({tag, ".stall0"}, stall, 1);
    check({tag, ".req0"}, bus_if.bus_req, 0);
    for (int k = 1; k <= gdly + 1; k++) begin
      @(negedge clk); #1;
      check({tag, ".req"}, bus_if.bus_req, 1);
      check({tag, ".we"}, bus_if.bus_we, 1);
      check({tag, ".addr"}, bus_if.bus_addr, e_addr);
      check({tag, ".strb"}, bus_if.bus_wstrb, e_strb);
      check({tag, ".wdata"}, bus_if.bus_wdata, e_wd);
      check({tag, ".stall"}, stall, 1);
      check({tag, ".nodone"}, done, 0);
      bus_if.bus_gnt = (k == gdly + 1);
    end
    @(negedge clk);
    bus_if.bus_gnt = 1'b0;
    #1;
    check({tag, ".done"}, done, 1);
    check({tag, ".mis"}, misalign, 0);
    check({tag, ".stall_done"}, stall, 0);
    check({tag, ".req_done"}, bus_if.bus_req, 0);
    idle_inputs();
  endtask

  task automatic do_load(input string tag, input logic [2:0] ld, input logic [31:0] addr,
                         input logic [31:0] rd, input int rwait,
                         input logic [31:0] e_addr, input logic [31:0] e_res);
    @(negedge clk);
    mem_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; load = ld; mem_addr = addr;
    #1;
    check({tag, ".stall0"}, stall, 1);
    @(negedge clk); #1;
    check({tag, ".req"}, bus_if.bus_req, 1);
    check({tag, ".we"}, bus_if.bus_we, 0);
    check({tag, ".strb"}, bus_if.bus_wstrb, 4'b0000);
    check({tag, ".addr"}, bus_if.bus_addr, e_addr);
    bus_if.bus_gnt = 1'b1;
    for (int j = 0; j <= rwait; j++) begin
      @(negedge clk);
      bus_if.bus_gnt = 1'b0;
      #1;
      check({tag, ".wait_stall"}, stall, 1);
      check({tag, ".wait_req"}, bus_if.bus_req, 0);
      check({tag, ".wait_done"}, done, 0);
      bus_if.bus_rvalid = (j == rwait);
      bus_if.bus_rdata  = (j == rwait) ? rd : ~rd;
    end
    @(negedge clk);
    bus_if.bus_rvalid = 1'b0;
    #1;
    check({tag, ".done"}, done, 1);
    check({tag, ".mis"}, misalign, 0);
    check({tag, ".rdata"}, mem_rdata, e_res);
    check({tag, ".stall_done"}, stall, 0);
    idle_inputs();
  endtask

  task automatic do_misalign(input string tag, input logic wr, input logic [2:0] ld,
                             input logic [1:0] st, input logic [31:0] addr,
                             input logic [31:0] e_rdata);
    @(negedge clk);
    mem_valid = 1'b1; is_store = wr; is_load = ~wr; load = ld; store = st;
    mem_addr = addr; mem_wdata = 32'h1234_5678;
    #1;
    check({tag, ".stall0"}, stall, 1);
    check({tag, ".req0"}, bus_if.bus_req, 0);
    @(negedge clk); #1;
    check({tag, ".done"}, done, 1);
    check({tag, ".mis"}, misalign, 1);
    check({tag, ".req1"}, bus_if.bus_req, 0);
    check({tag, ".stall1"}, stall, 0);
    check({tag, ".rdata_hold"}, mem_rdata, e_rdata);
    idle_inputs();
    @(negedge clk); #1;
    check({tag, ".after_done"}, done, 0);
    check({tag, ".after_mis"}, misalign, 0);
    check({tag, ".after_req"}, bus_if.bus_req, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    load = 3'b000; store = 2'b00; mem_addr = 32'h0; mem_wdata = 32'h0;
    bus_if.bus_rdata = 32'h0;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    check("rst.req", bus_if.bus_req, 0);
    check("rst.we", bus_if.bus_we, 0);
    check("rst.addr", bus_if.bus_addr, 0);
    check("rst.strb", bus_if.bus_wstrb, 0);
    check("rst.wdata", bus_if.bus_wdata, 0);
    check("rst.rdata", mem_rdata, 0);
    check("rst.done", done, 0);
    check("rst.mis", misalign, 0);
    check("rst.stall", stall, 0);
    rst_n = 1'b1;

    do_store("sb103", 2'b10, 1'b0, 32'h103, 32'h0000_00AB, 0,
             32'h100, 4'b1000, 32'hABAB_ABAB);
    do_load("lh202", 3'b001, 32'h202, 32'h80FF_1234, 3, 32'h200, 32'hFFFF_80FF);
    do_load("lhu202", 3'b011, 32'h202, 32'h80FF_1234, 3, 32'h200, 32'h0000_80FF);
    do_load("lb5", 3'b010, 32'h5, 32'h0000_8000, 0, 32'h4, 32'hFFFF_FF80);
    do_load("lbu5", 3'b100, 32'h5, 32'h0000_8000, 1, 32'h4, 32'h0000_0080);
    do_load("lw8", 3'b000, 32'h8, 32'hDEAD_BEEF, 0, 32'h8, 32'hDEAD_BEEF);
    do_load("lw_code7", 3'b111, 32'hC, 32'h0102_0304, 0, 32'hC, 32'h0102_0304);
    do_misalign("sw6", 1'b1, 3'b000, 2'b00, 32'h6, 32'h0102_0304);
    do_misalign("lh1", 1'b0, 3'b001, 2'b00, 32'h1, 32'h0102_0304);
    do_store("sh10", 2'b01, 1'b1, 32'h10, 32'h1234_5678, 4,
             32'h10, 4'b0011, 32'h5678_5678);
    check("hold.rdata", mem_rdata, 32'h0102_0304);
    do_store("sh12", 2'b01, 1'b0, 32'h12, 32'h0000_BEEF, 1,
             32'h10, 4'b1100, 32'hBEEF_BEEF);
    do_store("sw_code3", 2'b11, 1'b0, 32'h24, 32'hCAFE_F00D, 0,
             32'h24, 4'b1111, 32'hCAFE_F00D);
    do_store("sb_off1", 2'b10, 1'b0, 32'h31, 32'hFFFF_FF5A, 0,
             32'h30, 4'b0010, 32'h5A5A_5A5A);

    // Reset while waiting for read data; a late rvalid must be ignored.
    @(negedge clk);
    mem_valid = 1'b1; is_load = 1'b1; load = 3'b000; mem_addr = 32'h20;
    @(negedge clk); #1;
    check("rstmid.req", bus_if.bus_req, 1);
    bus_if.bus_gnt = 1'b1;
    @(negedge clk);
    bus_if.bus_gnt = 1'b0;
    #1;
    check("rstmid.wait_stall", stall, 1);
    rst_n = 1'b0;
    mem_valid = 1'b0; is_load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'hCAFE_F00D;
    #1;
    check("rstmid.req0", bus_if.bus_req, 0);
    check("rstmid.stall0", stall, 0);
    check("rstmid.rdata0", mem_rdata, 0);
    @(negedge clk);
    bus_if.bus_rvalid = 1'b0;
    #1;
    check("rstmid.nodone", done, 0);
    check("rstmid.rdata1", mem_rdata, 0);
    check("rstmid.req1", bus_if.bus_req, 0);
    @(negedge clk); #1;
    check("rstmid.nodone2", done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
